core_bus_arbiter: RTL and testbench

- Merges the core's INSTR and DATA bus master ports onto a single memory-side bus.
- Uses the same req/gnt/rvalid protocol on both sides.
- Sits directly downstream of the core bus interfaces: the master drivers and monitor attach at its inputs, and the slave driver attaches at its memory side.
- Tracks outstanding transactions in order and routes each response back to the issuing port.

---
 rtl/core_pkg.sv | 5 +
 rtl/core_bus_id_fifo.sv | 40 ++++
 rtl/core_bus_arbiter.sv | 85 ++++++++
 tb/tb_core_bus_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared port-ID and arbiter-state types for the core bus arbiter
package core_pkg;
    typedef enum logic {INSTR = 1'b0, DATA = 1'b1} core_if_e;
    typedef enum logic [1:0] {IDLE, LOCK_INSTR, LOCK_DATA} arb_state_e;
endpackage

// File: rtl/core_bus_id_fifo.sv
// core_bus_id_fifo: 1-bit-wide in-order ID queue of granted, unanswered transactions
module core_bus_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic          mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin merge of INSTR/DATA master ports onto one memory bus
module core_bus_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);
    arb_state_e state;
    core_if_e   rr_last, pick, sel;
    logic       err, push, full, empty, head;

    core_bus_id_fifo #(.DEPTH(MAX_OUTST)) u_id_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push (push),
        .pop  (mem_rvalid_i),
        .din  (sel),
        .full (full),
        .empty(empty),
        .head (head)
    );

    // pick a requester, let a pending lock override it, and mux the address phase
    always_comb begin
        pick           = (instr_req_i && data_req_i) ? ((rr_last == INSTR) ? DATA : INSTR)
                                                     : (data_req_i ? DATA : INSTR);
        sel            = (state == LOCK_DATA) ? DATA : (state == LOCK_INSTR) ? INSTR : pick;
        mem_req_o      = (state != IDLE) || ((instr_req_i || data_req_i) && !full);
        mem_addr_o     = (sel == DATA) ? data_addr_i : instr_addr_i;
        mem_we_o       = (sel == DATA) && data_we_i;
        mem_be_o       = (sel == DATA) ? data_be_i : '1;
        mem_wdata_o    = (sel == DATA) ? data_wdata_i : '0;
        push           = mem_req_o && mem_gnt_i;
        instr_gnt_o    = push && (sel == INSTR);
        data_gnt_o     = push && (sel == DATA);
        instr_rvalid_o = mem_rvalid_i && !empty && (head == INSTR);
        data_rvalid_o  = mem_rvalid_i && !empty && (head == DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        err_o          = err;
    end

    // lock an ungranted address phase, remember the last winner, latch spurious responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rr_last <= INSTR;
            err     <= 1'b0;
        end else begin
            if (push) begin
                state   <= IDLE;
                rr_last <= sel;
            end else if (mem_req_o) begin
                state <= (sel == DATA) ? LOCK_DATA : LOCK_INSTR;
            end
            if (mem_rvalid_i && empty) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed and random checks against a queue-based reference model
module tb_core_bus_arbiter;
    localparam int MAX = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ireq = 0, dreq = 0, dwe = 0, gnt = 0, rvalid = 0;
    logic [31:0] iaddr = 0, daddr = 0, dwdata = 0, rdata = 0;
    logic [3:0]  dbe = 0;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic        mem_req_o, mem_we_o, err_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    int          vectors = 0, miscompares = 0;
    int          q[$];
    int          pend = -1, rr = 0;
    bit          err = 0, lig = 0, ldg = 0;

    core_bus_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: predict from the model, compare mid-cycle, then advance the model
    task automatic cyc();
        int sel;
        bit req, eig, edg, eiv, edv;
        @(negedge clk);
        req = 0;
        sel = 0;
        if (pend >= 0) begin
            req = 1;
            sel = pend;
        end else if (q.size() < MAX && (ireq || dreq)) begin
            req = 1;
            sel = (ireq && dreq) ? 1 - rr : (dreq ? 1 : 0);
        end
        eig = req && gnt && sel == 0;
        edg = req && gnt && sel == 1;
        eiv = rvalid && q.size() > 0 && q[0] == 0;
        edv = rvalid && q.size() > 0 && q[0] == 1;
        if (!rst) begin
            check("flags", 128'({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o}),
                  128'({req, eig, edg, eiv, edv, err}));
            if (req)
                check("aphase", 128'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}),
                      sel == 1 ? 128'({daddr, dwe, dbe, dwdata}) : 128'({iaddr, 1'b0, 4'hf, 32'h0}));
            check("rdata", 128'({instr_rdata_o, data_rdata_o}), 128'({rdata, rdata}));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            pend = -1;
            rr = 0;
            err = 0;
        end else begin
            if (rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1;
            end
            if (req && gnt) begin
                q.push_back(sel);
                rr = sel;
                pend = -1;
            end else if (req) begin
                pend = sel;
            end
        end
        lig = eig;
        ldg = edg;
        #1;
    endtask

    task automatic drain();
        ireq = 0;
        dreq = 0;
        gnt = 0;
        for (int i = 0; i < 8; i++) begin
            rvalid = q.size() > 0;
            rdata = $urandom;
            cyc();
        end
        rvalid = 0;
    endtask

    initial begin
        cyc();
        rst = 0;
        cyc();
        ireq = 1; iaddr = 32'h100; gnt = 1;
        #2 check("t1_gnt", 128'({instr_gnt_o, data_gnt_o}), 128'b10);
        check("t1_addr", 128'(mem_addr_o), 128'h100);
        cyc();
        ireq = 0; gnt = 0; rvalid = 1; rdata = 32'hDEADBEEF;
        #2 check("t1_rv", 128'({instr_rvalid_o, data_rvalid_o}), 128'b10);
        check("t1_rdata", 128'(instr_rdata_o), 128'hDEADBEEF);
        cyc();
        rvalid = 0;
        rst = 1;
        cyc();
        rst = 0;
        ireq = 1; dreq = 1; iaddr = 32'h140; daddr = 32'h240; dwe = 0; dbe = 4'h3; gnt = 1;
        for (int k = 0; k < 4; k++) begin
            #2 check("t2_order", 128'({instr_gnt_o, data_gnt_o}), k % 2 == 0 ? 128'b01 : 128'b10);
            cyc();
        end
        ireq = 0; dreq = 0; gnt = 0; rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            rdata = $urandom;
            #2 check("t2_route", 128'({instr_rvalid_o, data_rvalid_o}), k % 2 == 0 ? 128'b01 : 128'b10);
            cyc();
        end
        rvalid = 0;
        dreq = 1; daddr = 32'h300; gnt = 1;
        cyc();
        drain();
        dreq = 1; daddr = 32'h200; dwe = 1; dbe = 4'hf; dwdata = $urandom; gnt = 0;
        for (int k = 0; k < 3; k++) begin
            #2 check("t3_lock", 128'({mem_addr_o, mem_we_o, instr_gnt_o}), 128'({32'h200, 1'b1, 1'b0}));
            cyc();
            ireq = 1;
        end
        gnt = 1;
        #2 check("t3_dgnt", 128'({instr_gnt_o, data_gnt_o}), 128'b01);
        cyc();
        dreq = 0; dwe = 0;
        #2 check("t3_ignt", 128'({instr_gnt_o, data_gnt_o}), 128'b10);
        cyc();
        drain();
        ireq = 1; gnt = 1;
        for (int k = 0; k < 4; k++) cyc();
        #2 check("t4_full", 128'(mem_req_o), 128'h0);
        cyc();
        rvalid = 1;
        #2 check("t4_popsame", 128'({mem_req_o, instr_rvalid_o}), 128'b01);
        cyc();
        rvalid = 0;
        #2 check("t4_popnext", 128'({mem_req_o, instr_gnt_o}), 128'b11);
        cyc();
        drain();
        for (int n = 0; n < 400; n++) begin
            if (!ireq || lig) begin
                ireq = 1'($urandom_range(0, 1));
                iaddr = $urandom;
            end
            if (!dreq || ldg) begin
                dreq = 1'($urandom_range(0, 1));
                daddr = $urandom;
                dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom);
                dwdata = $urandom;
            end
            gnt = 1'($urandom_range(0, 1));
            rvalid = q.size() > 0 && $urandom_range(0, 2) != 0;
            rdata = $urandom;
            cyc();
        end
        drain();
        drain();
        rvalid = 1;
        #2 check("t6_norv", 128'({instr_rvalid_o, data_rvalid_o}), 128'b00);
        cyc();
        rvalid = 0;
        cyc();
        cyc();
        #2 check("t6_held", 128'(err_o), 128'h1);
        rst = 1;
        cyc();
        rst = 0;
        #2 check("t6_reset", 128'({err_o, mem_req_o}), 128'b00);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
